// File: rtl/bp_update_arbiter.sv
// Branch-update arbiter: buffers up to NUM_REQ resolved branches per cycle, feeds one predictor write per cycle.
// Latency >= 1 cycle (0 with BP_UPD_BYPASS_EN); req_ready is all-or-nothing from registered count, upd_hold stalls the head.
`ifndef BRANCH_HISTORY_REG_SZ
`define BRANCH_HISTORY_REG_SZ 8
`endif

module bp_update_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int DEPTH     = 8,
   parameter int ADDR_W    = 32,
   parameter int BHR_DEPTH = `BRANCH_HISTORY_REG_SZ
) (
   input  logic                          clock_i,
   input  logic                          reset_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ-1:0]            req_taken_i,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_pc_i,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_target_i,
   input  logic [NUM_REQ*BHR_DEPTH-1:0]  req_bhr_i,
   output logic                          req_ready_o,
   input  logic                          upd_hold_i,
   output logic                          wr_en_o,
   output logic                          wr_taken_o,
   output logic [ADDR_W-1:0]             wr_pc_o,
   output logic [ADDR_W-1:0]             wr_target_o,
   output logic [BHR_DEPTH-1:0]          wr_bhr_o,
   output logic [$clog2(DEPTH+1)-1:0]    count_o,
   output logic [31:0]                   issued_cnt_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [ADDR_W-1:0]    pc_q  [DEPTH];
   logic [ADDR_W-1:0]    tgt_q [DEPTH];
   logic [BHR_DEPTH-1:0] bhr_q [DEPTH];
   logic [DEPTH-1:0]     taken_q;
   logic [DEPTH-1:0]     vld_q, vld_d;

   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [31:0]          issued_q, issued_d;

   logic                 pop;
   logic                 byp_vld;
   logic [IDX_W-1:0]     byp_idx;
   logic [NUM_REQ-1:0]   acc;
   logic [CNT_W-1:0]     push_cnt;
   logic [DEPTH-1:0]     ent_we;
   logic [IDX_W-1:0]     ent_src [DEPTH];

   // Pointer advance wraps by compare so non-power-of-2 depths work.
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int n);
      int s;
      s = int'(p) + n;
      if (s >= DEPTH) s = s - DEPTH;
      return PTR_W'(s);
   endfunction

   assign req_ready_o = (int'(count_q) + NUM_REQ) <= DEPTH;
   assign pop         = (count_q != '0) && vld_q[head_q] && !upd_hold_i;

`ifdef BP_UPD_BYPASS_EN
   always_comb begin
      byp_vld = 1'b0;
      byp_idx = '0;
      if ((count_q == '0) && !upd_hold_i && req_ready_o && (|req_valid_i)) begin
         byp_vld = 1'b1;
         for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (req_valid_i[i]) byp_idx = IDX_W'(i);
         end
      end
   end
`else
   assign byp_vld = 1'b0;
   assign byp_idx = '0;
`endif

   // Accepted requests are compacted into consecutive slots from tail in index order.
   always_comb begin
      int off;
      logic [PTR_W-1:0] slot;
      off     = 0;
      slot    = '0;
      ent_we  = '0;
      ent_src = '{default: '0};
      acc     = req_ready_o ? req_valid_i : '0;
      if (byp_vld) acc[byp_idx] = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (acc[i]) begin
            slot          = wrap_add(tail_q, off);
            ent_we[slot]  = 1'b1;
            ent_src[slot] = IDX_W'(i);
            off           = off + 1;
         end
      end
      push_cnt = CNT_W'(off);
      tail_d   = wrap_add(tail_q, off);
   end

   always_comb begin
      head_d   = pop ? wrap_add(head_q, 1) : head_q;
      count_d  = count_q + push_cnt - {{(CNT_W-1){1'b0}}, pop};
      issued_d = issued_q + {31'd0, wr_en_o};
      vld_d    = vld_q;
      if (pop) vld_d[head_q] = 1'b0;
      vld_d    = vld_d | ent_we;
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         issued_q <= '0;
         vld_q    <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         issued_q <= issued_d;
         vld_q    <= vld_d;
      end
   end

   always_ff @(posedge clock_i) begin
      for (int j = 0; j < DEPTH; j++) begin
         if (ent_we[j]) begin
            pc_q[j]    <= req_pc_i[int'(ent_src[j])*ADDR_W +: ADDR_W];
            tgt_q[j]   <= req_target_i[int'(ent_src[j])*ADDR_W +: ADDR_W];
            bhr_q[j]   <= req_bhr_i[int'(ent_src[j])*BHR_DEPTH +: BHR_DEPTH];
            taken_q[j] <= req_taken_i[ent_src[j]];
         end
      end
   end

   // pop and byp_vld are mutually exclusive: bypass only fires when empty.
   always_comb begin
      wr_taken_o  = 1'b0;
      wr_pc_o     = '0;
      wr_target_o = '0;
      wr_bhr_o    = '0;
      if (pop) begin
         wr_taken_o  = taken_q[head_q];
         wr_pc_o     = pc_q[head_q];
         wr_target_o = tgt_q[head_q];
         wr_bhr_o    = bhr_q[head_q];
      end else if (byp_vld) begin
         wr_taken_o  = req_taken_i[byp_idx];
         wr_pc_o     = req_pc_i[int'(byp_idx)*ADDR_W +: ADDR_W];
         wr_target_o = req_target_i[int'(byp_idx)*ADDR_W +: ADDR_W];
         wr_bhr_o    = req_bhr_i[int'(byp_idx)*BHR_DEPTH +: BHR_DEPTH];
      end
   end

   assign wr_en_o      = pop | byp_vld;
   assign count_o      = count_q;
   assign issued_cnt_o = issued_q;

endmodule
